spi_prefetch_fifo: RTL and testbench

- Multi-entry prefetch buffer between the SPI flash read controller and the RLE/VGA consumer.
- Generalises the single-word SPI buffer to DEPTH entries of parametrised width, with optional empty-bypass, a back-pressure request to the SPI controller, flush on new read, and overflow/underflow flags.
- Lets the SPI controller run ahead of the pixel pipeline, so line-time jitter does not starve the decoder.

---
 rtl/spi_prefetch_fifo.sv | 118 +++++++++++
 tb/tb_spi_prefetch_fifo.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_prefetch_fifo.sv
// Prefetch FIFO between the SPI flash read controller and the pixel decoder.
// DEPTH-entry ring buffer with optional empty-bypass, back-pressure, flush and sticky error flags.
module spi_prefetch_fifo #(
    parameter int DATA_WIDTH_BYTES = 4,
    parameter int DEPTH            = 4,
    parameter int PAUSE_MARGIN     = 1,
    parameter int BYPASS           = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start_read,
    input  logic [DATA_WIDTH_BYTES*8-1:0]    data_in,
    input  logic                             data_valid,
    input  logic                             rd_en,
    output logic [DATA_WIDTH_BYTES*8-1:0]    data_out,
    output logic                             data_ready,
    output logic                             empty,
    output logic                             full,
    output logic [$clog2(DEPTH+1)-1:0]       level,
    output logic                             spi_pause,
    output logic                             overflow,
    output logic                             underflow
);

    localparam int   W        = DATA_WIDTH_BYTES * 8;
    localparam int   LW       = $clog2(DEPTH + 1);
    localparam int   PW       = $clog2(DEPTH);
    localparam int   PAUSE_AT = DEPTH - PAUSE_MARGIN;
    localparam logic BYP      = (BYPASS != 0);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic ready_raw;
    logic bypass;
    logic pop;
    logic push;
    logic drop;

    assign empty     = (level_q == '0);
    assign full      = (level_q == LW'(DEPTH));
    assign level     = level_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign spi_pause = (int'(level_q) >= PAUSE_AT);

    assign ready_raw  = !empty || (BYP && data_valid);
    assign data_ready = ready_raw && !start_read;
    assign data_out   = (empty && BYP) ? data_in : mem_q[rd_ptr_q];

    // Push/pop qualification; flush gating is applied in the next-state logic.
    assign bypass = empty && BYP && data_valid && rd_en;
    assign pop    = rd_en && !empty;
    assign push   = data_valid && !bypass && (!full || pop);
    assign drop   = data_valid && full && !pop;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (start_read) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
            if (drop) begin
                overflow_d = 1'b1;
            end
            if (rd_en && !ready_raw) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left unreset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push && !start_read) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

endmodule

// File: tb/tb_spi_prefetch_fifo.sv
// Directed bench for spi_prefetch_fifo: one bypass instance and one store-first instance.
module tb_spi_prefetch_fifo;

    logic        clk;
    logic        rst;

    logic        start_read, data_valid, rd_en;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        data_ready, empty, full, spi_pause, overflow, underflow;
    logic [2:0]  level;

    logic        b_start_read, b_data_valid, b_rd_en;
    logic [31:0] b_data_in;
    logic [31:0] b_data_out;
    logic        b_data_ready, b_empty, b_full, b_spi_pause, b_overflow, b_underflow;
    logic [2:0]  b_level;

    int total;
    int bad;
    logic [31:0] model_q[$];
    logic [31:0] exp_w;

    spi_prefetch_fifo #(.DATA_WIDTH_BYTES(4), .DEPTH(4), .PAUSE_MARGIN(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .start_read(start_read), .data_in(data_in),
        .data_valid(data_valid), .rd_en(rd_en), .data_out(data_out),
        .data_ready(data_ready), .empty(empty), .full(full), .level(level),
        .spi_pause(spi_pause), .overflow(overflow), .underflow(underflow)
    );

    spi_prefetch_fifo #(.DATA_WIDTH_BYTES(4), .DEPTH(4), .PAUSE_MARGIN(1), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .start_read(b_start_read), .data_in(b_data_in),
        .data_valid(b_data_valid), .rd_en(b_rd_en), .data_out(b_data_out),
        .data_ready(b_data_ready), .empty(b_empty), .full(b_full), .level(b_level),
        .spi_pause(b_spi_pause), .overflow(b_overflow), .underflow(b_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        data_valid = 1'b0;
        rd_en      = 1'b0;
        start_read = 1'b0;
        data_in    = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        b_start_read = 1'b0; b_data_valid = 1'b0; b_rd_en = 1'b0; b_data_in = '0;
        #12;
        total++; if (level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
        total++; if (spi_pause !== 1'b0) begin bad++; $display("FAIL reset_pause got=%b exp=0", spi_pause); end
        total++; if ({overflow, underflow} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {overflow, underflow}); end
        total++; if (data_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", data_ready); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 4; i++) begin
            data_valid = 1'b1;
            data_in    = 32'h1111_1111 * (i + 1);
            tick();
            total++; if (level !== 3'(i + 1)) begin bad++; $display("FAIL fill_level[%0d] got=%0d exp=%0d", i, level, i + 1); end
            total++; if (full !== (i == 3)) begin bad++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full, (i == 3)); end
            total++; if (spi_pause !== (i >= 2)) begin bad++; $display("FAIL fill_pause[%0d] got=%b exp=%b", i, spi_pause, (i >= 2)); end
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            exp_w = 32'h1111_1111 * (i + 1);
            total++; if (data_out !== exp_w) begin bad++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, data_out, exp_w); end
            rd_en = 1'b1;
            tick();
        end
        idle();
        total++; if (empty !== 1'b1 || level !== 3'd0) begin bad++; $display("FAIL drain_empty got=%b/%0d exp=1/0", empty, level); end
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL drain_underflow got=%b exp=0", underflow); end
    endtask

    task automatic test_bypass();
        data_valid = 1'b1; rd_en = 1'b1; data_in = 32'hCAFE_F00D;
        #1;
        total++; if (data_out !== 32'hCAFE_F00D) begin bad++; $display("FAIL bypass_data got=%h exp=cafef00d", data_out); end
        total++; if (data_ready !== 1'b1) begin bad++; $display("FAIL bypass_ready got=%b exp=1", data_ready); end
        tick();
        idle();
        total++; if (level !== 3'd0) begin bad++; $display("FAIL bypass_level got=%0d exp=0", level); end
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL bypass_underflow got=%b exp=0", underflow); end

        b_data_valid = 1'b1; b_rd_en = 1'b1; b_data_in = 32'hCAFE_F00D;
        #1;
        total++; if (b_data_ready !== 1'b0) begin bad++; $display("FAIL nobyp_ready got=%b exp=0", b_data_ready); end
        tick();
        b_data_valid = 1'b0; b_rd_en = 1'b0; b_data_in = '0;
        #1;
        total++; if (b_underflow !== 1'b1) begin bad++; $display("FAIL nobyp_underflow got=%b exp=1", b_underflow); end
        total++; if (b_level !== 3'd1) begin bad++; $display("FAIL nobyp_level got=%0d exp=1", b_level); end
        total++; if (b_data_out !== 32'hCAFE_F00D || b_data_ready !== 1'b1) begin bad++; $display("FAIL nobyp_data got=%h/%b exp=cafef00d/1", b_data_out, b_data_ready); end
    endtask

    task automatic test_full_push_pop();
        model_q.delete();
        for (int i = 0; i < 4; i++) begin
            data_valid = 1'b1; data_in = 32'hA000_0000 + i;
            model_q.push_back(data_in);
            tick();
        end
        for (int j = 0; j < 6; j++) begin
            data_valid = 1'b1; rd_en = 1'b1; data_in = 32'hB000_0000 + j;
            #1;
            exp_w = model_q.pop_front();
            total++; if (data_out !== exp_w) begin bad++; $display("FAIL fpp_data[%0d] got=%h exp=%h", j, data_out, exp_w); end
            model_q.push_back(data_in);
            tick();
            total++; if (level !== 3'd4 || overflow !== 1'b0) begin bad++; $display("FAIL fpp_state[%0d] got=%0d/%b exp=4/0", j, level, overflow); end
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            exp_w = model_q.pop_front();
            total++; if (data_out !== exp_w) begin bad++; $display("FAIL fpp_drain[%0d] got=%h exp=%h", i, data_out, exp_w); end
            rd_en = 1'b1;
            tick();
        end
        idle();
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL fpp_empty got=%b exp=1", empty); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) begin
            data_valid = 1'b1; data_in = 32'hC000_0000 + i;
            tick();
        end
        data_valid = 1'b1; data_in = 32'hDEAD_BEEF;
        tick();
        idle();
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        total++; if (level !== 3'd4) begin bad++; $display("FAIL ovf_level got=%0d exp=4", level); end
        for (int i = 0; i < 4; i++) begin
            exp_w = 32'hC000_0000 + i;
            total++; if (data_out !== exp_w) begin bad++; $display("FAIL ovf_drain[%0d] got=%h exp=%h", i, data_out, exp_w); end
            rd_en = 1'b1;
            tick();
        end
        idle();
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
        start_read = 1'b1;
        tick();
        idle();
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    endtask

    task automatic test_flush_race();
        for (int i = 0; i < 3; i++) begin
            data_valid = 1'b1; data_in = 32'hD000_0000 + i;
            tick();
        end
        start_read = 1'b1; data_valid = 1'b1; rd_en = 1'b1; data_in = 32'hEEEE_EEEE;
        #1;
        total++; if (data_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b exp=0", data_ready); end
        tick();
        idle();
        total++; if (level !== 3'd0 || empty !== 1'b1) begin bad++; $display("FAIL flush_level got=%0d/%b exp=0/1", level, empty); end
        data_valid = 1'b1; data_in = 32'hF000_0000;
        tick();
        idle();
        total++; if (level !== 3'd1 || data_out !== 32'hF000_0000) begin bad++; $display("FAIL flush_push got=%0d/%h exp=1/f0000000", level, data_out); end
        total++; if (dut_a.mem_q[0] !== 32'hF000_0000) begin bad++; $display("FAIL flush_entry0 got=%h exp=f0000000", dut_a.mem_q[0]); end
        rd_en = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) begin
            data_valid = 1'b1; data_in = 32'h5000_0000 + i;
            tick();
        end
        idle();
        rd_en = 1'b1;
        tick();
        tick();
        idle();
        total++; if (level !== 3'd2 || overflow !== 1'b1) begin bad++; $display("FAIL arst_pre got=%0d/%b exp=2/1", level, overflow); end
        #2 rst = 1'b1;
        #1;
        total++; if (level !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL arst_level got=%0d/%b/%b exp=0/1/0", level, empty, full); end
        total++; if (overflow !== 1'b0 || underflow !== 1'b0 || spi_pause !== 1'b0) begin bad++; $display("FAIL arst_flags got=%b%b%b exp=000", overflow, underflow, spi_pause); end
        #1 rst = 1'b0;
        data_valid = 1'b1; data_in = 32'h6000_0001;
        tick();
        idle();
        total++; if (level !== 3'd1 || data_out !== 32'h6000_0001) begin bad++; $display("FAIL arst_resume got=%0d/%h exp=1/60000001", level, data_out); end
        total++; if (dut_a.mem_q[0] !== 32'h6000_0001) begin bad++; $display("FAIL arst_entry0 got=%h exp=60000001", dut_a.mem_q[0]); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_fill_drain();
        test_bypass();
        test_full_push_pop();
        test_overflow();
        test_flush_race();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
